// File: rtl/csr_hpm_counter_bank.sv
// Programmable HPM counter bank: mhpmcounter/mhpmevent/mcountinhibit with optional overflow flags.
// Overflow flags and IRQ are built only when RSD_HPM_OVERFLOW_IRQ_EN is defined.
module csr_hpm_counter_bank #(
    parameter int unsigned NUM_COUNTERS    = 4,
    parameter int unsigned COUNTER_WIDTH   = 64,
    parameter int unsigned EVENT_SEL_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [11:0]                     csrNumber,
    input  logic                            csrWE,
    input  logic [31:0]                     csrWriteData,
    output logic [31:0]                     csrReadOut,
    output logic                            csrHit,
    input  logic [(2**EVENT_SEL_WIDTH)-1:0] eventVec,
    output logic                            overflowIrq
);

    localparam int unsigned NUM_EVENTS = 2 ** EVENT_SEL_WIDTH;
    localparam int unsigned HI_W       = COUNTER_WIDTH - 32;

    logic [NUM_EVENTS-1:0]      r_ev;
    logic [COUNTER_WIDTH-1:0]   r_cnt [NUM_COUNTERS];
    logic [EVENT_SEL_WIDTH-1:0] r_sel [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]    r_inhibit;

    logic [COUNTER_WIDTH-1:0]   w_cnt_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]    w_wr_lo;
    logic [NUM_COUNTERS-1:0]    w_wr_hi;
    logic [NUM_COUNTERS-1:0]    w_wr_evt;
    logic [NUM_COUNTERS-1:0]    w_inc;
    logic [NUM_COUNTERS-1:0]    w_of;

    logic [4:0] w_low;
    logic [4:0] w_idx;
    logic       w_in_range;
    logic       w_sel_inh;
    logic       w_sel_evt;
    logic       w_sel_lo;
    logic       w_sel_hi;

    // Each region is a 32-entry block; slots 3..31 map to counters 0..28.
    assign w_low      = csrNumber[4:0];
    assign w_idx      = w_low - 5'd3;
    assign w_in_range = (w_low >= 5'd3);
    assign w_sel_inh  = (csrNumber[11:5] == 7'h19) && (w_low == 5'd0);
    assign w_sel_evt  = (csrNumber[11:5] == 7'h19) && w_in_range;
    assign w_sel_lo   = (csrNumber[11:5] == 7'h58) && w_in_range;
    assign w_sel_hi   = (csrNumber[11:5] == 7'h5C) && w_in_range;
    assign csrHit     = w_sel_inh | w_sel_evt | w_sel_lo | w_sel_hi;

    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            w_wr_lo[i]  = csrWE && w_sel_lo  && (w_idx == 5'(i));
            w_wr_hi[i]  = csrWE && w_sel_hi  && (w_idx == 5'(i));
            w_wr_evt[i] = csrWE && w_sel_evt && (w_idx == 5'(i));
            w_inc[i]    = r_ev[r_sel[i]] && (r_sel[i] != '0) && !r_inhibit[i]
                          && !w_wr_lo[i] && !w_wr_hi[i];
            w_cnt_d[i]  = r_cnt[i];
            if (w_wr_lo[i]) begin
                w_cnt_d[i][31:0] = csrWriteData;
            end else if (w_wr_hi[i]) begin
                w_cnt_d[i][COUNTER_WIDTH-1:32] = csrWriteData[HI_W-1:0];
            end else if (w_inc[i]) begin
                w_cnt_d[i] = r_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        csrReadOut = '0;
        if (w_sel_inh) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                csrReadOut[3+i] = r_inhibit[i];
            end
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (w_idx == 5'(i)) begin
                if (w_sel_evt) begin
                    csrReadOut[EVENT_SEL_WIDTH-1:0] = r_sel[i];
                    csrReadOut[31]                  = w_of[i];
                end else if (w_sel_lo) begin
                    csrReadOut = r_cnt[i][31:0];
                end else if (w_sel_hi) begin
                    csrReadOut = 32'(r_cnt[i][COUNTER_WIDTH-1:32]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev      <= '0;
            r_inhibit <= '0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cnt[i] <= '0;
                r_sel[i] <= '0;
            end
        end else begin
            r_ev <= eventVec;
            if (csrWE && w_sel_inh) begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    r_inhibit[i] <= csrWriteData[3+i];
                end
            end
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cnt[i] <= w_cnt_d[i];
                if (w_wr_evt[i]) begin
                    r_sel[i] <= csrWriteData[EVENT_SEL_WIDTH-1:0];
                end
            end
        end
    end

`ifdef RSD_HPM_OVERFLOW_IRQ_EN
    logic [NUM_COUNTERS-1:0] r_of;
    logic [NUM_COUNTERS-1:0] w_of_d;
    logic                    r_irq;

    // A wrap wins over a software clear in the same cycle.
    always_comb begin
        w_of_d = r_of;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (w_wr_evt[i]) begin
                w_of_d[i] = csrWriteData[31];
            end
            if (w_inc[i] && (&r_cnt[i])) begin
                w_of_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_of  <= '0;
            r_irq <= 1'b0;
        end else begin
            r_of  <= w_of_d;
            r_irq <= |r_of;
        end
    end

    assign w_of        = r_of;
    assign overflowIrq = r_irq;
`else
    assign w_of        = '0;
    assign overflowIrq = 1'b0;
`endif

endmodule

// File: tb/tb_csr_hpm_counter_bank.sv
// Directed bench for csr_hpm_counter_bank; expected values queued at drive time, popped at check.
module tb_csr_hpm_counter_bank;

    logic        clk;
    logic        rst;
    logic [11:0] csrNumber;
    logic        csrWE;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadOut;
    logic        csrHit;
    logic [15:0] eventVec;
    logic        overflowIrq;

    logic [31:0] exp_q [$];
    int          n_cmp;
    int          n_err;

    csr_hpm_counter_bank dut (
        .clk          (clk),
        .rst          (rst),
        .csrNumber    (csrNumber),
        .csrWE        (csrWE),
        .csrWriteData (csrWriteData),
        .csrReadOut   (csrReadOut),
        .csrHit       (csrHit),
        .eventVec     (eventVec),
        .overflowIrq  (overflowIrq)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic cmp(input logic [31:0] obs, input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic chk(input logic [11:0] a, input logic [31:0] e, input string tag);
        csrNumber = a;
        exp_q.push_back(e);
        #1;
        cmp(csrReadOut, tag);
    endtask

    task automatic chk_hit(input logic [11:0] a, input logic e, input string tag);
        csrNumber = a;
        exp_q.push_back({31'b0, e});
        #1;
        cmp({31'b0, csrHit}, tag);
    endtask

    task automatic chk_irq(input logic e, input string tag);
        exp_q.push_back({31'b0, e});
        #1;
        cmp({31'b0, overflowIrq}, tag);
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csrNumber    = a;
        csrWriteData = d;
        csrWE        = 1'b1;
        @(negedge clk);
        csrWE        = 1'b0;
    endtask

    logic of_en;

    initial begin
`ifdef RSD_HPM_OVERFLOW_IRQ_EN
        of_en = 1'b1;
`else
        of_en = 1'b0;
`endif
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; csrNumber = '0; csrWE = 1'b0; csrWriteData = '0; eventVec = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and address decode
        chk(12'hB03, 32'h0, "rst_lo");
        chk(12'hB83, 32'h0, "rst_hi");
        chk(12'h323, 32'h0, "rst_evt");
        chk(12'h320, 32'h0, "rst_inh");
        chk_irq(1'b0, "rst_irq");
        chk_hit(12'hB20, 1'b0, "hit_b20");
        chk(12'hB20, 32'h0, "rd_b20");
        chk_hit(12'hB03, 1'b1, "hit_b03");
        chk_hit(12'h321, 1'b0, "hit_321");

        // Event latency: five pulses of event 2 alongside event 1
        @(negedge clk);
        wr(12'h323, 32'h2);
        chk(12'h323, 32'h2, "sel_rd");
        eventVec = 16'h0006;
        chk(12'hB03, 32'h0, "lat_n");
        @(negedge clk);
        chk(12'hB03, 32'h0, "lat_n1");
        repeat (4) @(negedge clk);
        eventVec = '0;
        chk(12'hB03, 32'h4, "lat_4");
        @(negedge clk);
        chk(12'hB03, 32'h5, "lat_5");
        repeat (2) @(negedge clk);
        chk(12'hB03, 32'h5, "lat_hold");

        // Carry into the upper half with the event held high
        eventVec = 16'h0004;
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'h0);
        chk(12'hB03, 32'hFFFF_FFFF, "carry_pre_lo");
        chk(12'hB83, 32'h0, "carry_pre_hi");
        @(negedge clk);
        chk(12'hB03, 32'h0, "carry_lo");
        chk(12'hB83, 32'h1, "carry_hi");
        eventVec = '0;
        repeat (2) @(negedge clk);

        // Full wrap and overflow flag / IRQ
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        chk(12'hB83, 32'hFFFF_FFFF, "ones_hi");
        eventVec = 16'h0004;
        @(negedge clk);
        eventVec = '0;
        @(negedge clk);
        chk(12'hB03, 32'h0, "wrap_lo");
        chk(12'hB83, 32'h0, "wrap_hi");
        chk(12'h323, of_en ? 32'h8000_0002 : 32'h2, "wrap_of");
        chk_irq(1'b0, "irq_same");
        @(negedge clk);
        chk_irq(of_en, "irq_rise");
        wr(12'h323, 32'h2);
        chk_irq(of_en, "irq_clr_edge");
        @(negedge clk);
        chk_irq(1'b0, "irq_fall");
        chk(12'h323, 32'h2, "of_cleared");

        // Inhibit freezes counter 0, release resumes
        eventVec = 16'h0004;
        repeat (2) @(negedge clk);
        chk(12'hB03, 32'h1, "inh_pre");
        wr(12'h320, 32'h8);
        chk(12'hB03, 32'h2, "inh_set");
        chk(12'h320, 32'h8, "inh_rd");
        @(negedge clk);
        chk(12'hB03, 32'h2, "inh_frozen");
        wr(12'h320, 32'h0);
        chk(12'hB03, 32'h2, "inh_release");
        @(negedge clk);
        chk(12'hB03, 32'h3, "inh_resume");
        eventVec = '0;
        repeat (2) @(negedge clk);
        chk(12'hB03, 32'h4, "inh_drain");

        // Write collides with a counted event
        eventVec = 16'h0004;
        @(negedge clk);
        eventVec = '0;
        wr(12'hB03, 32'h0000_1234);
        chk(12'hB03, 32'h0000_1234, "coll_wr");
        @(negedge clk);
        chk(12'hB03, 32'h0000_1234, "coll_hold");
        chk(12'hB83, 32'h0, "coll_hi");

        // Unimplemented counter is WARL zero but still hits
        wr(12'hB07, 32'h0000_ABCD);
        chk(12'hB07, 32'h0, "unimpl_rd");
        chk_hit(12'hB07, 1'b1, "unimpl_hit");

        // Two counters on the same event
        wr(12'h324, 32'h2);
        eventVec = 16'h0004;
        @(negedge clk);
        eventVec = '0;
        repeat (2) @(negedge clk);
        chk(12'hB04, 32'h1, "share_c1");
        chk(12'hB03, 32'h0000_1235, "share_c0");

        // Software-set overflow flag
        wr(12'h323, 32'h8000_0002);
        chk(12'h323, of_en ? 32'h8000_0002 : 32'h2, "of_sw_set");

        // Reset mid-operation drops in-flight events
        eventVec = 16'h0004;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        eventVec = '0;
        repeat (2) @(negedge clk);
        chk(12'hB03, 32'h0, "mrst_c0");
        chk(12'hB04, 32'h0, "mrst_c1");
        chk(12'h324, 32'h0, "mrst_sel");
        chk(12'h323, 32'h0, "mrst_of");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csr_hpm_counter_bank.md
# csr_hpm_counter_bank

Parametrised hardware performance-monitor counter bank that replaces the fixed, hard-wired mhpmcounter3–6 read-only mapping in the CSR path. It provides NUM_COUNTERS counters, each with a software-programmable event selector, a global inhibit register (mcountinhibit), and a sticky overflow flag with an optional overflow interrupt request. It sits beside the CSR unit and decodes its own CSR numbers. The CSR unit muxes csrReadOut in when csrHit=1 and forwards the already-resolved write value (after WRITE/SET/CLEAR) on csrWriteData.

## Interface
Parameters:
- NUM_COUNTERS, default 4, number of implemented counters, range 1..29; counter i maps to mhpmcounter(3+i).
- COUNTER_WIDTH, default 64, counter width in bits, range 33..64.
- EVENT_SEL_WIDTH, default 4, selector width; NUM_EVENTS = 2**EVENT_SEL_WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- csrNumber  in  12  CSR address of the current CSR access.
- csrWE  in  1  write strobe; asserted at most one cycle per CSR instruction.
- csrWriteData  in  32  final value to store.
- csrReadOut  out  32  combinational read data for csrNumber.
- csrHit  out  1  csrNumber lies in this block's address space.
- eventVec  in  NUM_EVENTS  per-cycle event pulses; bit e=1 means one occurrence this cycle; bit 0 is ignored (means "no event").
- overflowIrq  out  1  registered OR of all overflow flags.

## Operation
- Address map (csrHit=1 for all of these):
  - 0x320 mcountinhibit: bit (3+i) inhibits counter i; other bits read 0 and are not writable.
  - 0x323+i mhpmevent(3+i): bits [EVENT_SEL_WIDTH-1:0] hold sel_i; bit 31 holds OF_i; other bits read 0.
  - 0xB03+i mhpmcounter(3+i): low 32 bits of counter i.
  - 0xB83+i mhpmcounterh(3+i): bits [COUNTER_WIDTH-1:32] of counter i, zero-extended to 32 bits.
- Address range for i = 0..28; any other address gives csrHit=0 and csrReadOut=0.
- i ≥ NUM_COUNTERS: reads 0, writes ignored (WARL), csrHit still 1.
- eventVec is registered into evReg every cycle. At each edge, counter i increments by 1 when all of the following hold:
  - evReg[sel_i]=1,
  - sel_i≠0,
  - inhibit bit is 0 (value held before that edge),
  - no write to counter i occurs this cycle.
- A write to the low or high half replaces only that half; the other half is preserved. The increment and carry for that counter are dropped in that cycle.
- Wrap: a counter at all-ones that increments becomes 0 and sets OF_i (sticky).
- Write to mhpmevent: sel_i and OF_i both take csrWriteData. Software may set or clear OF_i. If a wrap and a write to OF_i=0 coincide, OF_i ends at 1.
- Selector change takes effect for increments at the next edge after the write edge.

## Timing
- Reset values: all counters 0, sel 0, OF 0, mcountinhibit 0, evReg 0, overflowIrq 0. Outputs csrReadOut and csrHit follow csrNumber combinationally.
- Event latency: an event pulse in cycle N is captured at edge N+1, counted at edge N+2, and is visible to a read in cycle N+2.
- overflowIrq is registered from OF: a wrap at edge K sets OF at K, and overflowIrq rises at edge K+1. Clearing OF at edge J drops overflowIrq at edge J+1.
- Read data reflects register state before the current edge; no write-through bypass.
- A reset in mid-operation clears everything in that cycle, including in-flight evReg; events presented during the reset cycle are lost.
- Every counter updates independently in the same cycle; multiple counters may select the same event.

## Configuration
- RSD_HPM_OVERFLOW_IRQ_EN defined:
  - OF bits are implemented as described above,
  - overflowIrq is driven as described above.
- Undefined:
  - OF bits read 0 and writes to them are ignored,
  - overflowIrq is tied to 0,
  - counters still wrap silently,
  - no flag storage is synthesised.

## Test plan
- Reset, then read 0xB03, 0xB83, 0x323 and 0x320 -> all return 0; overflowIrq=0; a read of 0xB20 (i=29) gives csrHit=0.
- Write 0x323=2, pulse eventVec[2] in cycles 10–14 -> reading 0xB03 returns 0 in cycle 11 and 5 from cycle 16; eventVec[1] pulses are not counted.
- Write 0xB03=0xFFFFFFFF and 0xB83=0 with event held high -> after one increment 0xB03 reads 0 and 0xB83 reads 1 (carry into upper half).
- COUNTER_WIDTH=64, counter set to all-ones, one event -> counter reads 0 and 0x323 reads 0x80000002. Then:
  - overflowIrq=1 one cycle after the wrap,
  - writing 0x323=2 drops overflowIrq one cycle later,
  - with the macro undefined, 0x323 reads 0x2 and overflowIrq stays 0.
- Set 0x320 bit 3 while the event is held high -> counter 0 freezes at its value; clearing the bit resumes counting with no lost or extra counts beyond the pipeline delay.
- Write to 0xB03 in the same cycle a counted event arrives -> the counter equals the written value exactly. NUM_COUNTERS=4: writing 0xB07 leaves the read at 0.
